// File: rtl/c_wait_merge_n_if.sv
// c_wait_merge_n_if: handshake bundle for the N-input wait-merge join.
// CWAITMERGE_PROTOCOL_CHECK_EN adds the sticky protocol-error vector.
`default_nettype none

interface c_wait_merge_n_if #(
  parameter int NUM_CH = 3
);
  logic [NUM_CH-1:0] i_chanMask;
  logic [NUM_CH-1:0] i_drive;
  logic [NUM_CH-1:0] o_free;
  logic              o_driveNext;
  logic              i_freeNext;
  logic [NUM_CH-1:0] o_pending;
  logic              o_busy;
`ifdef CWAITMERGE_PROTOCOL_CHECK_EN
  logic [NUM_CH-1:0] o_protoErr;

  modport slave (
    input  i_chanMask, i_drive, i_freeNext,
    output o_free, o_driveNext, o_pending, o_busy, o_protoErr
  );
  modport master (
    output i_chanMask, i_drive, i_freeNext,
    input  o_free, o_driveNext, o_pending, o_busy, o_protoErr
  );
`else
  modport slave (
    input  i_chanMask, i_drive, i_freeNext,
    output o_free, o_driveNext, o_pending, o_busy
  );
  modport master (
    output i_chanMask, i_drive, i_freeNext,
    input  o_free, o_driveNext, o_pending, o_busy
  );
`endif
endinterface

`default_nettype wire

// File: rtl/c_wait_merge_n.sv
// ============================================================================
// c_wait_merge_n: N-channel clocked wait-merge join with programmable settle
// delay. Optional macro CWAITMERGE_PROTOCOL_CHECK_EN adds o_protoErr.
// Revision: 1.0
// ============================================================================
`default_nettype none

module c_wait_merge_n #(
  parameter int NUM_CH = 3,
  parameter int DELAY  = 1
) (
  input  logic              clk,
  input  logic              rst,
  c_wait_merge_n_if.slave   bus
);
  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_DELAY   = 2'd1,
    S_WAIT    = 2'd2
  } state_t;

  localparam logic       ZERO_DELAY = (DELAY == 0);
  localparam logic [7:0] DELAY_LOAD = 8'(DELAY);

  state_t            state, state_n;
  logic [NUM_CH-1:0] pend, pend_n;
  logic [NUM_CH-1:0] r_mask, mask_n;
  logic [7:0]        cnt, cnt_n;
  logic [NUM_CH-1:0] free_q, free_n;
  logic              drive_next_q, drive_next_n;
  logic              busy_q;
  logic [NUM_CH-1:0] arrived;
  logic              done;

  assign arrived = pend | (bus.i_drive & bus.i_chanMask);
  assign done    = (|bus.i_chanMask) & (&(arrived | ~bus.i_chanMask));

  always_comb begin
    state_n      = state;
    pend_n       = pend;
    mask_n       = r_mask;
    cnt_n        = cnt;
    free_n       = '0;
    drive_next_n = 1'b0;
    case (state)
      S_COLLECT: begin
        pend_n = arrived;
        if (done) begin
          mask_n = bus.i_chanMask;
          cnt_n  = DELAY_LOAD;
          if (ZERO_DELAY) begin
            state_n      = S_WAIT;
            drive_next_n = 1'b1;
          end else begin
            state_n = S_DELAY;
          end
        end
      end
      S_DELAY: begin
        cnt_n = cnt - 8'd1;
        if (cnt <= 8'd1) begin
          drive_next_n = 1'b1;
          state_n      = S_WAIT;
        end
      end
      S_WAIT: begin
        // A free arriving alongside our own drive pulse is premature and ignored.
        if (bus.i_freeNext && !drive_next_q) begin
          free_n  = r_mask;
          pend_n  = bus.i_drive & bus.i_chanMask;
          state_n = S_COLLECT;
        end
      end
      default: state_n = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_COLLECT;
      pend         <= '0;
      r_mask       <= '0;
      cnt          <= '0;
      free_q       <= '0;
      drive_next_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state        <= state_n;
      pend         <= pend_n;
      r_mask       <= mask_n;
      cnt          <= cnt_n;
      free_q       <= free_n;
      drive_next_q <= drive_next_n;
      busy_q       <= (state_n != S_COLLECT);
    end
  end

  assign bus.o_free      = free_q;
  assign bus.o_driveNext = drive_next_q;
  assign bus.o_pending   = pend;
  assign bus.o_busy      = busy_q;

`ifdef CWAITMERGE_PROTOCOL_CHECK_EN
  logic [NUM_CH-1:0] proto_err, proto_err_n;

  always_comb begin
    proto_err_n = proto_err
                | (bus.i_drive & pend)
                | (bus.i_drive & {NUM_CH{state != S_COLLECT}})
                | (bus.i_drive & free_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err <= '0;
    end else begin
      proto_err <= proto_err_n;
    end
  end

  assign bus.o_protoErr = proto_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_c_wait_merge_n.sv
// tb_c_wait_merge_n: table-driven directed checks of the wait-merge join
// (DELAY=2 and DELAY=0 instances) plus hand-written multi-cycle sequences.
`default_nettype none

module tb_c_wait_merge_n;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  c_wait_merge_n_if #(.NUM_CH(3)) bus_a ();
  c_wait_merge_n_if #(.NUM_CH(3)) bus_b ();

  c_wait_merge_n #(.NUM_CH(3), .DELAY(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  c_wait_merge_n #(.NUM_CH(3), .DELAY(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] mask;
    logic [2:0] drive;
    logic       fn;
    logic [2:0] free;
    logic       dn;
    logic [2:0] pend;
    logic       busy;
  } vec_t;

  vec_t vecs[31];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_a(input logic [2:0] m, input logic [2:0] d, input logic f);
    bus_a.i_chanMask = m;
    bus_a.i_drive    = d;
    bus_a.i_freeNext = f;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    // mask, drive, freeNext -> free, driveNext, pending, busy
    vecs[0]  = '{3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0};
    vecs[1]  = '{3'b111, 3'b001, 1'b0, 3'b000, 1'b0, 3'b001, 1'b0};
    vecs[2]  = '{3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 3'b001, 1'b0};
    vecs[3]  = '{3'b111, 3'b100, 1'b0, 3'b000, 1'b0, 3'b101, 1'b0};
    vecs[4]  = '{3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 3'b101, 1'b0};
    vecs[5]  = '{3'b111, 3'b010, 1'b0, 3'b000, 1'b0, 3'b111, 1'b1};
    vecs[6]  = '{3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 3'b111, 1'b1};
    vecs[7]  = '{3'b111, 3'b000, 1'b0, 3'b000, 1'b1, 3'b111, 1'b1};
    vecs[8]  = '{3'b111, 3'b000, 1'b1, 3'b000, 1'b0, 3'b111, 1'b1};
    vecs[9]  = '{3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 3'b111, 1'b1};
    vecs[10] = '{3'b111, 3'b000, 1'b1, 3'b111, 1'b0, 3'b000, 1'b0};
    vecs[11] = '{3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0};
    vecs[12] = '{3'b111, 3'b111, 1'b0, 3'b000, 1'b0, 3'b111, 1'b1};
    vecs[13] = '{3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 3'b111, 1'b1};
    vecs[14] = '{3'b111, 3'b000, 1'b0, 3'b000, 1'b1, 3'b111, 1'b1};
    vecs[15] = '{3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 3'b111, 1'b1};
    vecs[16] = '{3'b111, 3'b010, 1'b1, 3'b111, 1'b0, 3'b010, 1'b0};
    vecs[17] = '{3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 3'b010, 1'b0};
    vecs[18] = '{3'b111, 3'b101, 1'b0, 3'b000, 1'b0, 3'b111, 1'b1};
    vecs[19] = '{3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 3'b111, 1'b1};
    vecs[20] = '{3'b111, 3'b000, 1'b0, 3'b000, 1'b1, 3'b111, 1'b1};
    vecs[21] = '{3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 3'b111, 1'b1};
    vecs[22] = '{3'b111, 3'b000, 1'b1, 3'b111, 1'b0, 3'b000, 1'b0};
    vecs[23] = '{3'b111, 3'b001, 1'b0, 3'b000, 1'b0, 3'b001, 1'b0};
    vecs[24] = '{3'b111, 3'b010, 1'b0, 3'b000, 1'b0, 3'b011, 1'b0};
    vecs[25] = '{3'b011, 3'b000, 1'b0, 3'b000, 1'b0, 3'b011, 1'b1};
    vecs[26] = '{3'b011, 3'b000, 1'b0, 3'b000, 1'b0, 3'b011, 1'b1};
    vecs[27] = '{3'b011, 3'b000, 1'b0, 3'b000, 1'b1, 3'b011, 1'b1};
    vecs[28] = '{3'b011, 3'b000, 1'b0, 3'b000, 1'b0, 3'b011, 1'b1};
    vecs[29] = '{3'b011, 3'b000, 1'b1, 3'b011, 1'b0, 3'b000, 1'b0};
    vecs[30] = '{3'b011, 3'b100, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0};

    rst = 1'b1;
    set_a(3'b000, 3'b000, 1'b0);
    bus_b.i_chanMask = 3'b000;
    bus_b.i_drive    = 3'b000;
    bus_b.i_freeNext = 1'b0;
    tick();
    tick();
    chk("reset free",    32'(bus_a.o_free),      32'h0);
    chk("reset dn",      32'(bus_a.o_driveNext), 32'h0);
    chk("reset pending", 32'(bus_a.o_pending),   32'h0);
    chk("reset busy",    32'(bus_a.o_busy),      32'h0);
`ifdef CWAITMERGE_PROTOCOL_CHECK_EN
    chk("reset protoErr", 32'(bus_a.o_protoErr), 32'h0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 31; i++) begin
      set_a(vecs[i].mask, vecs[i].drive, vecs[i].fn);
      tick();
      chk($sformatf("v%0d free", i),    32'(bus_a.o_free),      32'(vecs[i].free));
      chk($sformatf("v%0d dn", i),      32'(bus_a.o_driveNext), 32'(vecs[i].dn));
      chk($sformatf("v%0d pending", i), 32'(bus_a.o_pending),   32'(vecs[i].pend));
      chk($sformatf("v%0d busy", i),    32'(bus_a.o_busy),      32'(vecs[i].busy));
    end
    set_a(3'b000, 3'b000, 1'b0);

    // DELAY=0 instance, mask 101: ch1 drive is ignored, driveNext the next cycle
    bus_b.i_chanMask = 3'b101;
    bus_b.i_drive    = 3'b111;
    tick();
    chk("b0 dn",      32'(bus_b.o_driveNext), 32'h1);
    chk("b0 pending", 32'(bus_b.o_pending),   32'h5);
    chk("b0 busy",    32'(bus_b.o_busy),      32'h1);
    bus_b.i_drive = 3'b000;
    tick();
    chk("b1 dn",   32'(bus_b.o_driveNext), 32'h0);
    chk("b1 busy", 32'(bus_b.o_busy),      32'h1);
    bus_b.i_freeNext = 1'b1;
    tick();
    chk("b2 free",    32'(bus_b.o_free),    32'h5);
    chk("b2 pending", 32'(bus_b.o_pending), 32'h0);
    chk("b2 busy",    32'(bus_b.o_busy),    32'h0);
    bus_b.i_freeNext = 1'b0;
    tick();
    chk("b3 free", 32'(bus_b.o_free), 32'h0);

    // All-zero mask never completes
    set_a(3'b000, 3'b111, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("m0 c%0d dn", i),      32'(bus_a.o_driveNext), 32'h0);
      chk($sformatf("m0 c%0d pending", i), 32'(bus_a.o_pending),   32'h0);
    end
    set_a(3'b000, 3'b000, 1'b0);
    tick();

`ifdef CWAITMERGE_PROTOCOL_CHECK_EN
    set_a(3'b111, 3'b111, 1'b0);
    tick();
    set_a(3'b111, 3'b000, 1'b0);
    tick();
    tick();
    chk("pe dn", 32'(bus_a.o_driveNext), 32'h1);
    chk("pe clean", 32'(bus_a.o_protoErr), 32'h0);
    set_a(3'b111, 3'b001, 1'b0);
    tick();
    chk("pe err", 32'(bus_a.o_protoErr), 32'h1);
    chk("pe busy", 32'(bus_a.o_busy), 32'h1);
    set_a(3'b111, 3'b000, 1'b1);
    tick();
    chk("pe free", 32'(bus_a.o_free), 32'h7);
    chk("pe sticky", 32'(bus_a.o_protoErr), 32'h1);
    set_a(3'b111, 3'b000, 1'b0);
    tick();
    chk("pe pending", 32'(bus_a.o_pending), 32'h0);
    chk("pe idle", 32'(bus_a.o_busy), 32'h0);
`endif

    // Reset in S_DELAY with everything pending
    set_a(3'b111, 3'b111, 1'b0);
    tick();
    chk("rm busy", 32'(bus_a.o_busy), 32'h1);
    set_a(3'b111, 3'b000, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("rm async pending", 32'(bus_a.o_pending),   32'h0);
    chk("rm async busy",    32'(bus_a.o_busy),      32'h0);
    chk("rm async dn",      32'(bus_a.o_driveNext), 32'h0);
    chk("rm async free",    32'(bus_a.o_free),      32'h0);
`ifdef CWAITMERGE_PROTOCOL_CHECK_EN
    chk("rm async protoErr", 32'(bus_a.o_protoErr), 32'h0);
`endif
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rm c%0d dn", i),   32'(bus_a.o_driveNext), 32'h0);
      chk($sformatf("rm c%0d busy", i), 32'(bus_a.o_busy),      32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
